// File: rtl/pipelined_rca_adder_if.sv
// Operand/result handshake bundle for pipelined_rca_adder.
// The master drives operands and out_ready; the slave (the adder) returns results.
interface pipelined_rca_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit carry segment per stage,
// a single global stall enable, and carry/signed-overflow flags from the last stage.
module pipelined_rca_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_rca_adder_if.slave bus
);

  localparam int STAGES = WIDTH / SEG;
  localparam int OPS    = (STAGES > 1) ? STAGES - 1 : 1;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  // Returns {carry_out, sum[SEG-1:0]}; the carry ripples bit by bit.
  function automatic logic [SEG:0] rca_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           c);
    logic [SEG:0] r;
    logic         carry;
    r     = {(SEG+1){1'b0}};
    carry = c;
    for (int i = 0; i < SEG; i++) begin
      r[i]  = fa_sum(x[i], y[i], carry);
      carry = fa_carry(x[i], y[i], carry);
    end
    r[SEG] = carry;
    return r;
  endfunction

  logic             en_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;
  logic             last_ovf_s;
  logic             ovf_r;

  logic             stage_valid_s [STAGES];
  logic [WIDTH-1:0] stage_sum_s   [STAGES];
  logic             stage_carry_s [STAGES];
  logic [WIDTH-1:0] fwd_a_s       [OPS];
  logic [WIDTH-1:0] fwd_b_s       [OPS];

  // Subtraction is a + ~b + !cin.
  assign b_eff_s = bus.b ^ {WIDTH{bus.sub}};
  assign c0_s    = bus.cin ^ bus.sub;

  assign en_s          = !stage_valid_s[STAGES-1] || bus.out_ready;
  assign bus.in_ready  = en_s;
  assign bus.out_valid = stage_valid_s[STAGES-1];
  assign bus.sum       = stage_sum_s[STAGES-1];
  assign bus.cout      = stage_carry_s[STAGES-1];
  assign bus.ovf       = ovf_r;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic             seg_cin_s;
    logic             valid_in_s;
    logic [WIDTH-1:0] sum_in_s;
    logic [SEG:0]     res_s;
    logic [WIDTH-1:0] sum_nxt_s;
    logic             valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;

    // Operands arrive right-aligned: the segment to add is always in [SEG-1:0].
    if (k == 0) begin : g_head
      assign op_a_s     = bus.a;
      assign op_b_s     = b_eff_s;
      assign seg_cin_s  = c0_s;
      assign valid_in_s = bus.in_valid;
      assign sum_in_s   = {WIDTH{1'b0}};
    end else begin : g_body
      assign op_a_s     = fwd_a_s[k-1];
      assign op_b_s     = fwd_b_s[k-1];
      assign seg_cin_s  = stage_carry_s[k-1];
      assign valid_in_s = stage_valid_s[k-1];
      assign sum_in_s   = stage_sum_s[k-1];
    end

    assign res_s = rca_seg(op_a_s[SEG-1:0], op_b_s[SEG-1:0], seg_cin_s);

    // Insert this stage's finished segment into the partial sum.
    always_comb begin
      sum_nxt_s                = sum_in_s;
      sum_nxt_s[k*SEG +: SEG]  = res_s[SEG-1:0];
    end

    // Stage register: valid, partial sum and segment carry advance together on en.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        sum_r   <= {WIDTH{1'b0}};
        carry_r <= 1'b0;
      end else if (en_s) begin
        valid_r <= valid_in_s;
        sum_r   <= sum_nxt_s;
        carry_r <= res_s[SEG];
      end
    end

    assign stage_valid_s[k] = valid_r;
    assign stage_sum_s[k]   = sum_r;
    assign stage_carry_s[k] = carry_r;

    if (k < STAGES - 1) begin : g_ops
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;

      // Unused upper operand bits travel alongside, shifted down one segment.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= {WIDTH{1'b0}};
          b_r <= {WIDTH{1'b0}};
        end else if (en_s) begin
          a_r <= op_a_s >> SEG;
          b_r <= op_b_s >> SEG;
        end
      end

      assign fwd_a_s[k] = a_r;
      assign fwd_b_s[k] = b_r;
    end

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    if (k == STAGES - 1) begin : g_tail
      assign last_ovf_s = res_s[SEG] ^
                          (op_a_s[SEG-1] ^ op_b_s[SEG-1] ^ res_s[SEG-1]);
    end
  end

  // Overflow flag register, aligned with the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (en_s) begin
      ovf_r <= last_ovf_s;
    end
  end

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed self-checking bench for pipelined_rca_adder (WIDTH=16, SEG=4).
module tb_pipelined_rca_adder;

  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  pipelined_rca_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_rca_adder #(.WIDTH(WIDTH), .SEG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stream vectors: a, b, cin, sub and hand-computed sum/cout/ovf.
  logic [15:0] va [8] = '{16'h1234, 16'hFFFF, 16'h4000, 16'h0010,
                          16'h0000, 16'h8000, 16'h1234, 16'h00FF};
  logic [15:0] vb [8] = '{16'h1111, 16'hFFFF, 16'h4000, 16'h0001,
                          16'h0001, 16'h8000, 16'h1234, 16'h0F01};
  logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        vs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] es [8] = '{16'h2345, 16'hFFFF, 16'h8000, 16'h000F,
                          16'hFFFF, 16'h0000, 16'hFFFF, 16'h1000};
  logic        ec [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        eo [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    bus.sub = sub;
  endtask

  // Single operation with out_ready=1; checks latency of exactly 3 edges.
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [15:0] x_sum,
                         input logic x_cout, input logic x_ovf);
    drive(a, b, cin, sub);
    bus.in_valid = 1'b1;
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("%s_valid_e%0d", tag, i), {31'd0, bus.out_valid},
            (i == 3) ? 32'd1 : 32'd0);
    end
    check({tag, "_sum"},  {16'd0, bus.sum},  {16'd0, x_sum});
    check({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, x_cout});
    check({tag, "_ovf"},  {31'd0, bus.ovf},  {31'd0, x_ovf});
    tick();
  endtask

  initial begin
    int          n;
    int          in_idx;
    int          out_idx;
    logic        hold_prev;
    logic [15:0] snap_sum;
    logic        snap_c;
    logic        snap_o;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);

    // Reset state before any clock edge.
    #3;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_sum",       {16'd0, bus.sum},       32'd0);
    check("rst_cout",      {31'd0, bus.cout},      32'd0);
    check("rst_ovf",       {31'd0, bus.ovf},       32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    #9;
    rst_n = 1'b1;
    tick();

    run_one("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("ovf_add", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("borrow",  16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);

    // Held result, then asynchronous reset in the middle of a cycle.
    bus.out_ready = 1'b0;
    drive(16'h8000, 16'h0001, 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    check("ovf_sub_latency", n, 32'd3);
    check("ovf_sub_sum",  {16'd0, bus.sum},  32'h7FFF);
    check("ovf_sub_cout", {31'd0, bus.cout}, 32'd1);
    check("ovf_sub_ovf",  {31'd0, bus.ovf},  32'd1);
    tick();
    tick();
    check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("hold_sum",      {16'd0, bus.sum},      32'h7FFF);
    check("hold_valid",    {31'd0, bus.out_valid}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_sum",       {16'd0, bus.sum},       32'd0);
    check("async_rst_cout",      {31'd0, bus.cout},      32'd0);
    check("async_rst_ovf",       {31'd0, bus.ovf},       32'd0);
    check("async_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    // Back-to-back stream with a 3-cycle output stall.
    in_idx    = 0;
    out_idx   = 0;
    hold_prev = 1'b0;
    snap_sum  = 16'h0000;
    snap_c    = 1'b0;
    snap_o    = 1'b0;
    for (int cyc = 0; cyc < 60 && out_idx < 8; cyc++) begin
      bus.out_ready = !(cyc >= 4 && cyc <= 6);
      if (in_idx < 8) begin
        drive(va[in_idx], vb[in_idx], vc[in_idx], vs[in_idx]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (hold_prev) begin
        check($sformatf("stable_sum_c%0d", cyc),   {16'd0, bus.sum},       {16'd0, snap_sum});
        check($sformatf("stable_cout_c%0d", cyc),  {31'd0, bus.cout},      {31'd0, snap_c});
        check($sformatf("stable_ovf_c%0d", cyc),   {31'd0, bus.ovf},       {31'd0, snap_o});
        check($sformatf("stable_valid_c%0d", cyc), {31'd0, bus.out_valid}, 32'd1);
      end
      if (!bus.out_ready && bus.out_valid) begin
        check($sformatf("stall_in_ready_c%0d", cyc), {31'd0, bus.in_ready}, 32'd0);
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      snap_sum  = bus.sum;
      snap_c    = bus.cout;
      snap_o    = bus.ovf;
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("stream_sum_%0d", out_idx),  {16'd0, bus.sum},  {16'd0, es[out_idx]});
        check($sformatf("stream_cout_%0d", out_idx), {31'd0, bus.cout}, {31'd0, ec[out_idx]});
        check($sformatf("stream_ovf_%0d", out_idx),  {31'd0, bus.ovf},  {31'd0, eo[out_idx]});
        out_idx++;
      end
      if (bus.in_valid && bus.in_ready) begin
        in_idx++;
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_count", out_idx, 32'd8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stream_no_extra_%0d", i), {31'd0, bus.out_valid}, 32'd0);
    end

    // Reset pulse with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      drive(va[i], vb[i], vc[i], vs[i]);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("flush_valid_%0d", i), {31'd0, bus.out_valid}, 32'd0);
    end
    run_one("post_rst", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/pipelined_rca_adder.md
# pipelined_rca_adder

Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshaking on both sides. It generalises the 4-bit combinational ripple-carry adder in three ways:
- operand width is configurable;
- the carry chain is cut into SEG-bit segments, with one segment per pipeline stage;
- it adds a subtract mode and carry/overflow flags.

It is the arithmetic building block for the datapath labs that follow, where a long combinational carry chain limits clock rate.

## Interface
- WIDTH, 16: operand and result width in bits; must be a multiple of SEG and at least SEG.
- SEG, 4: bits summed per pipeline stage. STAGES = WIDTH/SEG.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, asynchronous assert, active-low; all state is cleared while low.
- in_valid  in  1  operand set on a, b, cin, sub is valid.
- in_ready  out  1  block can accept an operand set this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in when sub=0; borrow-in when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b-cin.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  downstream accepts the result this cycle.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. For sub=1, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Operand preprocessing at the input:
  - b_eff = b XOR {WIDTH{sub}}.
  - c0 = cin XOR sub, so subtraction computes a + ~b + !cin = a - b - cin.
- Stage k (0..STAGES-1) holds:
  - a valid bit;
  - the finished sum bits [k*SEG+SEG-1:0];
  - the carry out of segment k;
  - the still-unused upper bits of a and b_eff, delayed alongside.
- Stage 0 computes segment 0 combinationally from the inputs and registers it on the accept edge.
- Stage k>0 adds segment k of its delayed operands plus stage k-1's carry, and registers the result on the advance edge.
- Inside each segment the carry ripples bit by bit through full adders (majority carry, XOR sum). No carry lookahead.
- Flags are produced by the last stage:
  - ovf uses the carry into bit WIDTH-1, taken from inside the last segment.
  - The last stage's registers drive sum/cout/ovf directly.
- Flow control is a single global enable: en = !out_valid || out_ready.
  - in_ready = en (combinational).
  - When en=1, every stage loads from its predecessor, valid bits included.
  - Stage 0 loads in_valid, so an idle input cycle inserts a bubble.
  - When en=0, all stages hold.
- A transfer happens on an edge with in_valid && in_ready (input side) or out_valid && out_ready (output side).
- Results leave strictly in acceptance order. None is dropped or duplicated.
- Outputs stay stable while out_valid=1 && out_ready=0.
- Reset (rst_n=0), effective immediately, mid-stream included:
  - all valid bits 0, so out_valid=0;
  - sum, cout, ovf = 0, and all data registers cleared;
  - in_ready=1 (follows from out_valid=0).
  - In-flight operations are discarded. No result for them ever appears after release.
- Simultaneous events:
  - Output accepted and new input accepted on the same edge: both occur, full throughput.
  - out_ready=0 with out_valid=1: the input is also stalled (in_ready=0), even if earlier stages hold bubbles.
- STAGES=1 (SEG=WIDTH) is legal and gives a single registered stage.

## Timing
- Latency: an operand accepted on rising edge t produces out_valid=1 after edge t+STAGES-1, given no stall. With the defaults, edge t+3.
- Throughput: one operation per cycle while out_ready=1.
- Each stall cycle (en=0) adds exactly one cycle to the latency of every in-flight operation.
- in_ready depends combinationally on out_ready. No other combinational input-to-output path exists.
- Reset assertion is asynchronous. Release is sampled on the first clk rise with rst_n=1. The first accept is possible on that edge.

## Test plan
- Reset: drive rst_n=0 mid-cycle. Expect out_valid=0, sum=0, cout=0, ovf=0, and in_ready=1 immediately, without waiting for a clk edge.
- Full carry ripple (WIDTH=16, SEG=4): a=16'hFFFF, b=16'h0001, cin=0, sub=0. Expect sum=16'h0000, cout=1, ovf=0, with out_valid exactly after accept edge +3.
- Signed overflow:
  - a=16'h7FFF, b=16'h0000, cin=1, sub=0 -> sum=16'h8000, cout=0, ovf=1.
  - a=16'h8000, b=16'h0001, cin=0, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
- Borrow: a=16'h0003, b=16'h0005, cin=1, sub=1 -> sum=16'hFFFD, cout=0, ovf=0.
- Backpressure: stream 8 back-to-back random operations and hold out_ready=0 for 3 cycles mid-stream. Expect in_ready=0 during the stall, output fields stable, and all 8 results matching a reference model, in order, with none lost or duplicated.
- Reset mid-flight: accept 3 operations, then pulse rst_n low for 1 cycle. Expect out_valid to stay 0 for at least 5 cycles after release. Expect a new operation accepted after release to complete normally with latency 3.
